video_bitstream_packer: RTL and testbench

- Writer-side complement of the video bitstream reader.
- Accepts variable-length codewords (1..32 bits, right-aligned) from an encoder/multiplexer and packs them MSB-first into 32-bit words.
- Buffers the words in an internal word FIFO and presents the stream one byte at a time, with a pop handshake, to the downstream byte sink (Ethernet/ZBT writer).
- Supports a flush that zero-pads the stream to a 32-bit boundary ahead of start codes; MPEG-2 zero stuffing makes this legal.

---
 rtl/video_bitstream_packer.sv | 235 +++++++++++++++++++++++
 tb/tb_video_bitstream_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_bitstream_packer.sv
// -----------------------------------------------------------------------------
// video_bitstream_packer
//
// Writer-side bit packer for a video elementary stream. Variable-length
// codewords (1..32 bits, right-aligned) are concatenated MSB-first into
// 32-bit words. Completed words go into a small word FIFO, which is presented
// to the byte sink one byte at a time with show-ahead data and a pop strobe.
// A flush zero-pads the pending bits up to the next 32-bit boundary, which is
// legal ahead of start codes because MPEG-2 allows zero stuffing.
//
// Optional feature macro: VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
//   When defined, adds Bit_Count_O: total bits accepted since reset,
//   including flush padding, wrapping modulo 2^32.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-high reset
//   Reset_Address_I  synchronous clear of accumulator, FIFO and byte select
//   Code_Valid_I     codeword present
//   Code_Data_I      codeword, right-aligned
//   Code_Length_I    codeword length 1..32 (0 = accepted no-op)
//   Code_Ready_O     codeword accepted when valid & ready
//   Flush_I          level request to pad to a 32-bit boundary
//   Flush_Done_O     one-cycle pulse after a flush executes
//   Byte_Allign_O    packed bit count is a multiple of 8
//   Buffer_Read_I    pop the current output byte
//   Byte_Data_O      current output byte (show-ahead)
//   Buffer_Empty_O   no byte available
//   Buffer_Full_O    word FIFO holds 2^ADDR_WIDTH words
//   Bit_Count_O      (optional) running bit count
// -----------------------------------------------------------------------------
module video_bitstream_packer #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Reset_Address_I,
  input  logic        Code_Valid_I,
  input  logic [31:0] Code_Data_I,
  input  logic [5:0]  Code_Length_I,
  output logic        Code_Ready_O,
  input  logic        Flush_I,
  output logic        Flush_Done_O,
  output logic        Byte_Allign_O,
  input  logic        Buffer_Read_I,
  output logic [7:0]  Byte_Data_O,
  output logic        Buffer_Empty_O,
  output logic        Buffer_Full_O
`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
  ,
  output logic [31:0] Bit_Count_O
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Accumulator: r_fill pending bits held left-aligned in r_acc, zeros below.
  logic [31:0]         r_acc;
  logic [4:0]          r_fill;

  // Word FIFO with a wrap bit on each pointer.
  logic [31:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;

  // Byte view of the head word.
  logic [1:0]          r_sel;
  logic [7:0]          r_byte;
  logic                r_empty;

  logic                r_flush_done;
  logic                r_allign;

  // Combinational next-state signals.
  logic                w_full;
  logic                w_accept;
  logic                w_flush_exec;
  logic [5:0]          w_len;
  logic [5:0]          w_sum;
  logic [6:0]          w_shift;
  logic [31:0]         w_mask;
  logic [63:0]         w_combined;
  logic                w_push;
  logic [31:0]         w_push_data;
  logic [31:0]         w_acc_next;
  logic [4:0]          w_fill_next;
  logic [5:0]          w_bits_added;

  logic                w_read;
  logic                w_pop;
  logic [1:0]          w_sel_next;
  logic [ADDR_WIDTH:0] w_rd_ptr_next;
  logic                w_empty_next;
  logic [31:0]         w_head_word;
  logic [7:0]          w_byte_next;

  // Full when the pointers differ only in the wrap bit.
  assign w_full = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                  (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  // Flush takes priority over codewords.
  assign Code_Ready_O   = ~w_full & ~Flush_I;
  assign Buffer_Full_O  = w_full;
  assign Flush_Done_O   = r_flush_done;
  assign Byte_Allign_O  = r_allign;
  assign Byte_Data_O    = r_byte;
  assign Buffer_Empty_O = r_empty;

  // Lengths above 32 are clamped so the shift arithmetic stays in range.
  assign w_len   = Code_Length_I[5] ? 6'd32 : Code_Length_I;
  assign w_mask  = (w_len == 6'd32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << w_len[4:0]) - 32'd1);
  assign w_sum   = {1'b0, r_fill} + w_len;
  // Places the new code directly under the pending bits in a 64-bit window;
  // a shift of 64 (zero-length code on an empty accumulator) yields zero.
  assign w_shift = 7'd64 - {2'b00, r_fill} - {1'b0, w_len};
  assign w_combined = {r_acc, 32'h0} | ({32'h0, Code_Data_I & w_mask} << w_shift);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_accept     = Code_Valid_I & Code_Ready_O;
    w_flush_exec = Flush_I & ~w_full;
    w_push       = 1'b0;
    w_push_data  = r_acc;
    w_acc_next   = r_acc;
    w_fill_next  = r_fill;
    w_bits_added = 6'd0;
    if (w_flush_exec) begin
      if (r_fill != 5'd0) begin
        // Lower bits of r_acc are already zero, so it is the padded word.
        w_push       = 1'b1;
        w_push_data  = r_acc;
        w_acc_next   = 32'h0;
        w_fill_next  = 5'd0;
        w_bits_added = 6'd32 - {1'b0, r_fill};
      end
    end else if (w_accept) begin
      w_bits_added = w_len;
      w_fill_next  = w_sum[4:0];  // equals sum-32 when a word completes
      if (w_sum >= 6'd32) begin
        w_push      = 1'b1;
        w_push_data = w_combined[63:32];
        w_acc_next  = w_combined[31:0];
      end else begin
        w_acc_next  = w_combined[63:32];
      end
    end
  end

  // Read side. The output register is loaded from the post-read pointer and
  // select but only from words committed before this edge, so a freshly
  // pushed word becomes visible one cycle after it lands in the FIFO.
  always_comb begin
    w_read        = Buffer_Read_I & ~r_empty;
    w_pop         = w_read & (r_sel == 2'd3);
    w_sel_next    = w_read ? r_sel + 2'd1 : r_sel;
    w_rd_ptr_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    w_empty_next  = (w_rd_ptr_next == r_wr_ptr);
    w_head_word   = r_mem[w_rd_ptr_next[ADDR_WIDTH-1:0]];
    w_byte_next   = 8'h00;
    if (!w_empty_next) begin
      case (w_sel_next)
        2'd0:    w_byte_next = w_head_word[31:24];
        2'd1:    w_byte_next = w_head_word[23:16];
        2'd2:    w_byte_next = w_head_word[15:8];
        default: w_byte_next = w_head_word[7:0];
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are valid, and leaving the array unreset keeps it mappable to RAM.
  always_ff @(posedge clock) begin
    if (w_push && !w_full && !Reset_Address_I) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_push_data;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc        <= 32'h0;
      r_fill       <= 5'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sel        <= 2'd0;
      r_byte       <= 8'h00;
      r_empty      <= 1'b1;
      r_flush_done <= 1'b0;
      r_allign     <= 1'b1;
    end else if (Reset_Address_I) begin
      // Discards pending bits and queued bytes; a concurrent code is dropped.
      r_acc        <= 32'h0;
      r_fill       <= 5'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sel        <= 2'd0;
      r_byte       <= 8'h00;
      r_empty      <= 1'b1;
      r_flush_done <= 1'b0;
      r_allign     <= 1'b1;
    end else begin
      r_acc        <= w_acc_next;
      r_fill       <= w_fill_next;
      if (w_push && !w_full) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr     <= w_rd_ptr_next;
      r_sel        <= w_sel_next;
      r_byte       <= w_byte_next;
      r_empty      <= w_empty_next;
      r_flush_done <= w_flush_exec;
      r_allign     <= (w_fill_next[2:0] == 3'd0);
    end
  end

`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
  logic [31:0] r_bit_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_count <= 32'h0;
    end else if (Reset_Address_I) begin
      r_bit_count <= 32'h0;
    end else begin
      r_bit_count <= r_bit_count + {26'h0, w_bits_added};
    end
  end

  assign Bit_Count_O = r_bit_count;
`endif

endmodule

// File: tb/tb_video_bitstream_packer.sv
// -----------------------------------------------------------------------------
// tb_video_bitstream_packer
//
// Scoreboard bench. The stimulus side feeds codewords into a bit-queue
// reference model; every completed 32-bit word becomes four expected bytes.
// A separate monitor compares each byte the sink pops against the queue.
// -----------------------------------------------------------------------------
module tb_video_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        Reset_Address_I;
  logic        Code_Valid_I;
  logic [31:0] Code_Data_I;
  logic [5:0]  Code_Length_I;
  logic        Code_Ready_O;
  logic        Flush_I;
  logic        Flush_Done_O;
  logic        Byte_Allign_O;
  logic        Buffer_Read_I;
  logic [7:0]  Byte_Data_O;
  logic        Buffer_Empty_O;
  logic        Buffer_Full_O;
`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
  logic [31:0] Bit_Count_O;
`endif

  video_bitstream_packer #(.ADDR_WIDTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .Reset_Address_I (Reset_Address_I),
    .Code_Valid_I    (Code_Valid_I),
    .Code_Data_I     (Code_Data_I),
    .Code_Length_I   (Code_Length_I),
    .Code_Ready_O    (Code_Ready_O),
    .Flush_I         (Flush_I),
    .Flush_Done_O    (Flush_Done_O),
    .Byte_Allign_O   (Byte_Allign_O),
    .Buffer_Read_I   (Buffer_Read_I),
    .Byte_Data_O     (Byte_Data_O),
    .Buffer_Empty_O  (Buffer_Empty_O),
    .Buffer_Full_O   (Buffer_Full_O)
`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
    ,
    .Bit_Count_O     (Bit_Count_O)
`endif
  );

  // Rising edges at 5, 15, ...; inputs change on falling edges.
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: pending bits in stream order, expected output bytes.
  bit          pend[$];
  logic [7:0]  exp_q[$];
  logic [31:0] model_bits = 32'h0;

  // Reader control.
  bit rd_enable = 1'b0;
  int rd_pct    = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit_word();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 32; i++) w = {w[30:0], pend.pop_front()};
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic model_accept(input logic [31:0] d, input int len);
    for (int i = len - 1; i >= 0; i--) pend.push_back(d[i]);
    model_bits += 32'(len);
    while (pend.size() >= 32) emit_word();
  endtask

  task automatic model_flush();
    if (pend.size() > 0) begin
      model_bits += 32'(32 - pend.size());
      while (pend.size() < 32) pend.push_back(1'b0);
      emit_word();
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_code(input logic [31:0] d, input int len);
    int waited = 0;
    Code_Valid_I  = 1'b1;
    Code_Data_I   = d;
    Code_Length_I = 6'(len);
    forever begin
      #3;
      if (Code_Ready_O) begin
        model_accept(d, len);
        @(negedge clock);
        break;
      end
      @(negedge clock);
      waited++;
      if (waited > 2000) begin
        check("code_accept_timeout", 32'h0, 32'h1);
        break;
      end
    end
    Code_Valid_I = 1'b0;
    check("byte_allign", {31'h0, Byte_Allign_O}, {31'h0, (pend.size() % 8) == 0});
  endtask

  task automatic do_flush();
    int waited = 0;
    Flush_I = 1'b1;
    forever begin
      #3;
      check("ready_low_in_flush", {31'h0, Code_Ready_O}, 32'h0);
      if (!Buffer_Full_O) begin
        model_flush();
        break;
      end
      @(negedge clock);
      waited++;
      if (waited > 2000) begin
        check("flush_timeout", 32'h0, 32'h1);
        break;
      end
    end
    @(negedge clock);
    Flush_I = 1'b0;
    check("flush_done_pulse", {31'h0, Flush_Done_O}, 32'h1);
    check("allign_after_flush", {31'h0, Byte_Allign_O}, 32'h1);
    @(negedge clock);
    check("flush_done_single", {31'h0, Flush_Done_O}, 32'h0);
  endtask

  task automatic drain(input string name);
    int waited = 0;
    rd_pct    = 100;
    rd_enable = 1'b1;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() == 0 && Buffer_Empty_O) break;
      waited++;
      if (waited > 3000) begin
        check({name, "_drain_timeout"}, exp_q.size(), 32'h0);
        break;
      end
    end
    repeat (3) @(negedge clock);
    check({name, "_empty_after_drain"}, {31'h0, Buffer_Empty_O}, 32'h1);
  endtask

  // Reader: randomly pops while enabled.
  initial begin
    Buffer_Read_I = 1'b0;
    forever begin
      @(negedge clock);
      Buffer_Read_I = rd_enable && ($urandom_range(0, 99) < rd_pct);
    end
  end

  // Monitor: every accepted pop is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && !Reset_Address_I && Buffer_Read_I && !Buffer_Empty_O) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, Byte_Data_O}, 32'hFFFF_FFFF);
        end else begin
          check("byte_data", {24'h0, Byte_Data_O}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset           = 1'b1;
    Reset_Address_I = 1'b0;
    Code_Valid_I    = 1'b0;
    Code_Data_I     = 32'h0;
    Code_Length_I   = 6'd0;
    Flush_I         = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'h0, Code_Ready_O}, 32'h1);
    check("rst_flush_done", {31'h0, Flush_Done_O}, 32'h0);
    check("rst_allign", {31'h0, Byte_Allign_O}, 32'h1);
    check("rst_byte", {24'h0, Byte_Data_O}, 32'h0);
    check("rst_empty", {31'h0, Buffer_Empty_O}, 32'h1);
    check("rst_full", {31'h0, Buffer_Full_O}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Sequence header start code, with the two-cycle latency.
    send_code(32'h0000_0001, 24);
    send_code(32'h0000_00B3, 8);
    check("latency_empty_c1", {31'h0, Buffer_Empty_O}, 32'h1);
    @(negedge clock);
    check("latency_empty_c2", {31'h0, Buffer_Empty_O}, 32'h0);
    check("latency_first_byte", {24'h0, Byte_Data_O}, 32'h00);
    drain("seqhdr");

    // Three-bit code then flush: A0 00 00 00.
    send_code(32'hFFFF_FFFD, 3);
    do_flush();
    drain("flush3");

    // Split word: FFFFFFFF then flush FFFF8000.
    rd_enable = 1'b0;
    send_code(32'h0001_FFFF, 17);
    send_code(32'hFFFF_FFFF, 32);
    do_flush();
    drain("split");

    // Backpressure: 16 words fill the FIFO, the 17th waits.
    rd_enable = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 16; i++) send_code(32'h1234_5678 + 32'(i), 32);
    fork
      send_code(32'h9ABC_DEF0, 32);
      begin
        #3;
        check("bp_full", {31'h0, Buffer_Full_O}, 32'h1);
        check("bp_ready", {31'h0, Code_Ready_O}, 32'h0);
        repeat (4) @(negedge clock);
        #3;
        check("bp_still_full", {31'h0, Buffer_Full_O}, 32'h1);
        rd_pct    = 100;
        rd_enable = 1'b1;
      end
    join
    drain("backpressure");

    // Flush on an aligned stream: pulse only, nothing pushed.
    do_flush();
    repeat (3) @(negedge clock);
    check("aligned_flush_empty", {31'h0, Buffer_Empty_O}, 32'h1);
    check("aligned_flush_model", exp_q.size(), 32'h0);

    // Mid-stream clear with two words queued and five bits pending.
    rd_enable = 1'b0;
    repeat (3) @(negedge clock);
    send_code(32'hCAFE_F00D, 32);
    send_code(32'h0BAD_BEEF, 32);
    send_code(32'h0000_0015, 5);
    @(negedge clock);
    check("pre_clear_empty", {31'h0, Buffer_Empty_O}, 32'h0);
    check("pre_clear_allign", {31'h0, Byte_Allign_O}, 32'h0);
    Reset_Address_I = 1'b1;
    Code_Valid_I    = 1'b1;  // dropped because the clear has priority
    Code_Data_I     = 32'hFF;
    Code_Length_I   = 6'd8;
    @(negedge clock);
    Reset_Address_I = 1'b0;
    Code_Valid_I    = 1'b0;
    pend.delete();
    exp_q.delete();
    model_bits = 32'h0;
    check("clear_empty", {31'h0, Buffer_Empty_O}, 32'h1);
    check("clear_allign", {31'h0, Byte_Allign_O}, 32'h1);
    check("clear_full", {31'h0, Buffer_Full_O}, 32'h0);
`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
    check("clear_bit_count", Bit_Count_O, 32'h0);
`endif

    // Randomized traffic with a random-rate reader.
    rd_pct    = $urandom_range(30, 90);
    rd_enable = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        send_code($urandom, $urandom_range(0, 32));
      end
      if (n % 100 == 99) rd_pct = $urandom_range(10, 100);
    end
`ifdef VIDEO_BITSTREAM_PACKER_BIT_COUNT_EN
    check("rand_bit_count", Bit_Count_O, model_bits);
`endif
    do_flush();
    drain("random");
    check("final_model_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
